// File: rtl/x86_gpr_pkg.sv
// Shared constants for the x86 general-purpose register file.
package x86_gpr_pkg;

  // Word register indices
  localparam logic [2:0] AX = 3'd0;
  localparam logic [2:0] CX = 3'd1;
  localparam logic [2:0] DX = 3'd2;
  localparam logic [2:0] BX = 3'd3;
  localparam logic [2:0] SP = 3'd4;
  localparam logic [2:0] BP = 3'd5;
  localparam logic [2:0] SI = 3'd6;
  localparam logic [2:0] DI = 3'd7;

  // Byte register encodings (addr[2] picks the high byte of addr[1:0])
  localparam logic [2:0] AL = 3'd0;
  localparam logic [2:0] CL = 3'd1;
  localparam logic [2:0] DL = 3'd2;
  localparam logic [2:0] BL = 3'd3;
  localparam logic [2:0] AH = 3'd4;
  localparam logic [2:0] CH = 3'd5;
  localparam logic [2:0] DH = 3'd6;
  localparam logic [2:0] BH = 3'd7;

  // Default parameter values
  localparam int          GPR_DATA_W = 16;
  localparam int          GPR_NUM_RD = 3;
  localparam int          GPR_BYPASS = 1;
  localparam logic [15:0] GPR_SP_RST = 16'hFFFE;

endpackage

// File: rtl/x86_gpr_read_port.sv
// One read port: register select, optional write forwarding, byte extract.
module x86_gpr_read_port
  import x86_gpr_pkg::*;
#(
  parameter int DATA_W = GPR_DATA_W,
  parameter int BYPASS = GPR_BYPASS
) (
  input  logic [2:0]        addr,
  input  logic              w,
  input  logic [DATA_W-1:0] regs [8],
  input  logic [7:0]        busy_vec,
  input  logic              fwd_en,
  input  logic [2:0]        fwd_reg,
  input  logic [DATA_W-1:0] fwd_word,
  output logic [DATA_W-1:0] data,
  output logic              busy
);

  logic [2:0]        tgt;
  logic              hit;
  logic [DATA_W-1:0] word;

  // Resolve the target word, substitute the post-write word on a forwarding
  // hit, then narrow to a zero-extended byte for byte reads.
  always_comb begin
    tgt  = w ? addr : {1'b0, addr[1:0]};
    hit  = (BYPASS != 0) && fwd_en && (fwd_reg == tgt);
    word = hit ? fwd_word : regs[tgt];
    if (w)
      data = word;
    else if (addr[2])
      data = {{(DATA_W-8){1'b0}}, word[15:8]};
    else
      data = {{(DATA_W-8){1'b0}}, word[7:0]};
    // A same-cycle write releases the reservation, so show it as free.
    busy = busy_vec[tgt] && !hit;
  end

endmodule

// File: rtl/x86_gpr_file.sv
// x86 GPR file: 8 word registers with byte access, reservations and xchg.
module x86_gpr_file
  import x86_gpr_pkg::*;
#(
  parameter int                DATA_W = GPR_DATA_W,
  parameter int                NUM_RD = GPR_NUM_RD,
  parameter int                BYPASS = GPR_BYPASS,
  parameter logic [DATA_W-1:0] SP_RST = GPR_SP_RST
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*3-1:0]      rd_addr,
  input  logic [NUM_RD-1:0]        rd_w,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [2:0]               wr_addr,
  input  logic                     wr_w,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rsv_valid,
  input  logic [2:0]               rsv_addr,
  output logic                     rsv_ready,
  input  logic                     xchg_en,
  input  logic [2:0]               xchg_a,
  input  logic [2:0]               xchg_b,
  output logic [7:0]               busy_vec,
  output logic                     collision
);

  logic [DATA_W-1:0] regs_q [8];
  logic [7:0]        busy_q;
  logic              collision_q;

  logic [2:0]        wr_reg;
  logic              wr_eff;
  logic [DATA_W-1:0] wr_merged;
  logic              rsv_acc;
  logic              xchg_ok;
  logic [7:0]        busy_nxt;

  // Decode the write target, build the merged post-write word, and work out
  // which requests take effect this cycle (xchg always drops a write).
  always_comb begin
    wr_reg    = wr_w ? wr_addr : {1'b0, wr_addr[1:0]};
    wr_eff    = wr_en && !xchg_en;
    wr_merged = regs_q[wr_reg];
    if (wr_w)
      wr_merged = wr_data;
    else if (wr_addr[2])
      wr_merged[15:8] = wr_data[7:0];
    else
      wr_merged[7:0] = wr_data[7:0];
    rsv_ready = !busy_q[rsv_addr];
    rsv_acc   = rsv_valid && rsv_ready;
    xchg_ok   = xchg_en && !busy_q[xchg_a] && !busy_q[xchg_b];
  end

  // Busy update: a write releases its register, an accepted reserve sets it
  // afterwards so the reservation wins on the same register.
  always_comb begin
    busy_nxt = busy_q;
    if (wr_eff)
      busy_nxt[wr_reg] = 1'b0;
    if (rsv_acc)
      busy_nxt[rsv_addr] = 1'b1;
  end

  // Register storage: reset values, then xchg over write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++)
        regs_q[i] <= (i == int'(SP)) ? SP_RST : '0;
    end else if (xchg_ok) begin
      regs_q[xchg_a] <= regs_q[xchg_b];
      regs_q[xchg_b] <= regs_q[xchg_a];
    end else if (wr_eff) begin
      regs_q[wr_reg] <= wr_merged;
    end
  end

  // Reservation bits and the one-cycle collision pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q      <= '0;
      collision_q <= 1'b0;
    end else begin
      busy_q      <= busy_nxt;
      collision_q <= xchg_en && (wr_en || busy_q[xchg_a] || busy_q[xchg_b]);
    end
  end

  assign busy_vec  = busy_q;
  assign collision = collision_q;

  genvar g;
  generate
    for (g = 0; g < NUM_RD; g++) begin : g_rd
      x86_gpr_read_port #(
        .DATA_W (DATA_W),
        .BYPASS (BYPASS)
      ) u_port (
        .addr     (rd_addr[3*g +: 3]),
        .w        (rd_w[g]),
        .regs     (regs_q),
        .busy_vec (busy_q),
        .fwd_en   (wr_eff),
        .fwd_reg  (wr_reg),
        .fwd_word (wr_merged),
        .data     (rd_data[DATA_W*g +: DATA_W]),
        .busy     (rd_busy[g])
      );
    end
  endgenerate

endmodule

// File: doc/x86_gpr_file.md
X86_GPR_FILE -- requirements
Module: x86_gpr_file

Interface
REQ-001 Parameter DATA_W, default 16: register width in bits; byte mode requires DATA_W = 16.
REQ-002 Parameter NUM_RD, default 3: number of independent read ports.
REQ-003 Parameter BYPASS, default 1: 1 enables same-cycle write-to-read forwarding.
REQ-004 Parameter SP_RST, default 16'hFFFE: reset value of SP (index 4).
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 rd_addr  in  NUM_RD*3  per-port register encoding, port i at bits [3i+2:3i].
REQ-008 rd_w  in  NUM_RD  per-port width select: 1 = word, 0 = byte.
REQ-009 rd_data  out  NUM_RD*DATA_W  per-port read data; byte reads zero-extended.
REQ-010 rd_busy  out  NUM_RD  per-port flag: addressed register is reserved.
REQ-011 wr_en / wr_addr / wr_w / wr_data  in  1/3/1/DATA_W  write request, encoding, width and data.
REQ-012 rsv_valid / rsv_addr  in  1/3  reservation request for word register rsv_addr.
REQ-013 rsv_ready  out  1  reservation can be accepted this cycle.
REQ-014 xchg_en / xchg_a / xchg_b  in  1/3/3  word swap request for registers xchg_a and xchg_b.
REQ-015 busy_vec  out  8  busy bit per word register.
REQ-016 collision  out  1  registered one-cycle pulse flagging a rejected operation.

Function
REQ-017 Storage: 8 word registers, AX,CX,DX,BX,SP,BP,SI,DI at indices 0-7.
REQ-018 Word encoding (w=1): addr selects register addr directly.
REQ-019 Byte encoding (w=0): addr[2]=0 selects low byte, addr[2]=1 selects high byte of register addr[1:0] (AL,CL,DL,BL,AH,CH,DH,BH).
REQ-020 Reads: combinational, zero latency; a byte read returns {8'h00, byte}.
REQ-021 Write: on a clock edge with wr_en=1, the addressed word or byte is updated; the other byte of a byte write is preserved.
REQ-022 Bypass (BYPASS=1): a read overlapping the bytes written in the same cycle returns the merged post-write value; non-overlapping bytes read stored data; BYPASS=0 returns stored data.
REQ-023 Reserve: rsv_ready = !busy_vec[rsv_addr]; rsv_valid and rsv_ready set busy_vec[rsv_addr] at the next edge.
REQ-024 Release: any write (word or byte) to register r clears busy_vec[r] at the edge.
REQ-025 Simultaneous accepted reserve and write to the same non-busy register: write data is stored and busy ends set (reservation wins).
REQ-026 rd_busy[i] = busy_vec[target register of port i], which is rd_addr[1:0] for byte reads; with BYPASS=1 it reads 0 when the same-cycle write releases that register.
REQ-027 Xchg: xchg_en swaps the two full words in one edge; xchg_a = xchg_b is a no-op with no collision.
REQ-028 Xchg has priority over write; if xchg_en and wr_en occur in the same cycle, the write is dropped and collision pulses on the next cycle.
REQ-029 Xchg with either operand busy is suppressed entirely and collision pulses on the next cycle.
REQ-030 Xchg does not change busy_vec and is not forwarded by bypass.

Reset
REQ-031 While rst=1 at an edge: every register except SP is cleared to 0, SP is loaded with SP_RST, busy_vec is cleared to 0, and collision is cleared to 0.
REQ-032 rst takes priority over any write, reserve or xchg presented in the same cycle, all of which are discarded.
REQ-033 After reset, rd_data reflects the reset values and rsv_ready = 1.

Structure
REQ-034 The shared package x86_gpr_pkg SHALL hold the register index constants (AX..DI), the byte-register constants (AL..BH) and the default parameter values.
REQ-035 The per-port select, zero-extend and bypass logic SHALL be a sub-module x86_gpr_read_port, instantiated NUM_RD times through a generate loop.

Verification
REQ-036 Reset, then read AX, SP and AH -> 16'h0000, 16'hFFFE and 16'h0000; busy_vec = 8'h00.
REQ-037 Word write AX=16'h1234, then byte write AH(addr 4)=8'hAB -> AX reads 16'hAB34, AL reads 16'h0034; with a same-cycle read of AX and BYPASS=1 -> 16'hAB34 in that cycle.
REQ-038 Reserve BX -> busy_vec = 8'h08 and rsv_ready = 0 for BX; write BL=8'h55 -> busy clears, BX = 16'h0055.
REQ-039 Reserve DX and write DX in the same cycle with DX not busy -> DX holds the data and busy_vec[2] = 1.
REQ-040 With CX=16'h1111 and SI=16'h2222, xchg CX,SI -> CX=16'h2222, SI=16'h1111; xchg together with wr_en -> write dropped and collision = 1 for exactly one cycle.
REQ-041 Assert rst during an active reserve, write and xchg -> all registers hold reset values, busy_vec = 0 and collision = 0.
